// File: rtl/process_images_pkg.sv
// Shared types and helpers for the process_images pipelined arithmetic blocks.
// sat_narrow range-checks a sign/zero-extended value against a narrower result width.
package process_images_pkg;

    localparam int MAX_NUM_STAGE = 8;
    localparam int WIDE_W        = 64;

    localparam logic [WIDE_W-1:0] WIDE_ONE = WIDE_W'(1);

    typedef struct packed {
        logic              ovf;
        logic [WIDE_W-1:0] result;
    } narrow_t;

    // value must already be extended to WIDE_W bits according to is_signed.
    function automatic narrow_t sat_narrow(input logic [WIDE_W-1:0] value,
                                           input int unsigned       width,
                                           input logic              is_signed);
        narrow_t           r;
        logic [WIDE_W-1:0] max_v;
        logic [WIDE_W-1:0] min_v;
        logic              neg;
        logic              fits;
        if (is_signed) begin
            max_v = (WIDE_ONE << (width - 1)) - WIDE_ONE;
            min_v = ~max_v;
            neg   = value[WIDE_W-1];
            fits  = neg ? ($signed(value) >= $signed(min_v))
                        : ($signed(value) <= $signed(max_v));
        end else begin
            max_v = (WIDE_ONE << width) - WIDE_ONE;
            min_v = '0;
            neg   = 1'b0;
            fits  = (value <= max_v);
        end
        r.ovf    = ~fits;
        r.result = fits ? value : (neg ? min_v : max_v);
        return r;
    endfunction

endpackage

// File: rtl/process_images_mul_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier.
// master = producer of operands and consumer of results; slave = the multiplier.
interface process_images_mul_pipe_if #(
    parameter int din0_WIDTH = 20,
    parameter int din1_WIDTH = 20,
    parameter int dout_WIDTH = 20
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/process_images_pipe_reg.sv
// Rigid shift-register chain of DEPTH words sharing one enable.
// Every stage moves together; empty slots are carried, never collapsed.
module process_images_pipe_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // NOTE: holding every stage first gives each output a value on all paths, so no latch is inferred.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // NOTE: the chain is a handful of flops rather than a RAM, so clearing it on reset is cheap and keeps data deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/process_images_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control, clock enable,
// post-scale right shift and saturating or wrapping narrowing into a registered result.
module process_images_mul_pipe
    import process_images_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 20,
    parameter int din1_WIDTH = 20,
    parameter int dout_WIDTH = 20,
    parameter int SIGNED     = 1,
    parameter int SHIFT      = 0,
    parameter int SATURATE   = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ce,
    process_images_mul_pipe_if.slave  bus
);
    localparam int P = din0_WIDTH + din1_WIDTH;
    localparam int unused_id = ID;

    logic                  adv;
    logic signed [P-1:0]   a_ext;
    logic signed [P-1:0]   b_ext;
    logic [P-1:0]          prod_in;
    logic [P-1:0]          prod_tail;
    logic                  valid_tail;
    logic [P-1:0]          scaled;
    logic [WIDE_W-1:0]     wide;
    narrow_t               nr;
    logic                  unused_hi;

    logic                  out_valid_q, out_valid_d;
    logic [dout_WIDTH-1:0] dout_q,      dout_d;
    logic                  ovf_q,       ovf_d;

    // A held result blocks the whole pipeline until the consumer takes it.
    assign adv          = ce & (~out_valid_q | bus.out_ready);
    assign bus.in_ready = adv;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext = P'($signed(bus.din0));
            b_ext = P'($signed(bus.din1));
        end else begin
            a_ext = P'(bus.din0);
            b_ext = P'(bus.din1);
        end
        prod_in = a_ext * b_ext;
    end

    generate
        if (NUM_STAGE > 1) begin : g_chain
            process_images_pipe_reg #(.WIDTH(1), .DEPTH(NUM_STAGE - 1)) u_valid_chain (
                .clk   (ap_clk),
                .rst_n (ap_rst_n),
                .en    (adv),
                .din   (bus.in_valid),
                .dout  (valid_tail)
            );
            process_images_pipe_reg #(.WIDTH(P), .DEPTH(NUM_STAGE - 1)) u_prod_chain (
                .clk   (ap_clk),
                .rst_n (ap_rst_n),
                .en    (adv),
                .din   (prod_in),
                .dout  (prod_tail)
            );
        end else begin : g_direct
            assign valid_tail = bus.in_valid;
            assign prod_tail  = prod_in;
        end
    endgenerate

    // Shift floors toward minus infinity; the wide copy keeps the sign for range checking.
    always_comb begin
        if (SIGNED != 0) begin
            scaled = P'($signed(prod_tail) >>> SHIFT);
            wide   = WIDE_W'($signed(scaled));
        end else begin
            scaled = prod_tail >> SHIFT;
            wide   = WIDE_W'(scaled);
        end
        nr = sat_narrow(wide, dout_WIDTH, SIGNED != 0);
    end

    assign unused_hi = ^nr.result[WIDE_W-1:dout_WIDTH];

    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        if (adv) begin
            out_valid_d = valid_tail;
            dout_d      = (SATURATE != 0) ? nr.result[dout_WIDTH-1:0] : wide[dout_WIDTH-1:0];
            ovf_d       = nr.ovf;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_process_images_mul_pipe.sv
// Directed bench: three multiplier variants (saturating, wrapping, SHIFT=4) share one stimulus
// stream; each scenario task compares results against hand-computed values.
module tb_process_images_mul_pipe;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ce;
    logic        in_valid;
    logic        out_ready;
    logic [19:0] din0;
    logic [19:0] din1;

    int          n_checks;
    int          n_fail;
    logic [19:0] got [8];
    int          got_n;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    process_images_mul_pipe_if #(.din0_WIDTH(20), .din1_WIDTH(20), .dout_WIDTH(20)) if_a ();
    process_images_mul_pipe_if #(.din0_WIDTH(20), .din1_WIDTH(20), .dout_WIDTH(20)) if_b ();
    process_images_mul_pipe_if #(.din0_WIDTH(20), .din1_WIDTH(20), .dout_WIDTH(20)) if_c ();

    assign if_a.in_valid = in_valid;  assign if_a.din0 = din0;
    assign if_a.din1 = din1;          assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;  assign if_b.din0 = din0;
    assign if_b.din1 = din1;          assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.din0 = din0;
    assign if_c.din1 = din1;          assign if_c.out_ready = out_ready;

    process_images_mul_pipe #(.SATURATE(1), .SHIFT(0)) u_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if_a.slave));
    process_images_mul_pipe #(.SATURATE(0), .SHIFT(0)) u_wrap (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if_b.slave));
    process_images_mul_pipe #(.SATURATE(1), .SHIFT(4)) u_shift (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if_c.slave));

    // One operand pair through all three variants; returns the edges until out_valid.
    task automatic mul_once(input logic [19:0] a, input logic [19:0] b, output int lat,
                            output logic [20:0] ra, output logic [20:0] rb, output logic [20:0] rc);
        din0 = a; din1 = b; in_valid = 1'b1; out_ready = 1'b1; ce = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (if_a.out_valid !== 1'b1 && lat < 20) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        ra = {if_a.ovf, if_a.dout};
        rb = {if_b.ovf, if_b.dout};
        rc = {if_c.ovf, if_c.dout};
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        n_checks++;
        if ({if_a.out_valid, if_a.ovf, if_a.dout, if_c.out_valid, if_c.ovf, if_c.dout} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_state: got a=%b/%b/%h c=%b/%b/%h, expected all zero",
                     if_a.out_valid, if_a.ovf, if_a.dout, if_c.out_valid, if_c.ovf, if_c.dout);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_signed();
        int lat; logic [20:0] ra, rb, rc;
        mul_once(20'hFFFFD, 20'd5, lat, ra, rb, rc);   // -3 * 5
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL latency: got %0d expected 3", lat); end
        n_checks++;
        if (ra !== {1'b0, 20'hFFFF1}) begin n_fail++; $display("FAIL neg3x5_sat: got %h expected %h", ra, {1'b0, 20'hFFFF1}); end
        n_checks++;
        if (rb !== {1'b0, 20'hFFFF1}) begin n_fail++; $display("FAIL neg3x5_wrap: got %h expected %h", rb, {1'b0, 20'hFFFF1}); end
        n_checks++;
        if (rc !== {1'b0, 20'hFFFFF}) begin n_fail++; $display("FAIL neg3x5_shift: got %h expected %h", rc, {1'b0, 20'hFFFFF}); end
        mul_once(20'h0012C, 20'hFFF38, lat, ra, rb, rc); // 300 * -200 = -60000
        n_checks++;
        if (ra !== {1'b0, 20'hF15A0}) begin n_fail++; $display("FAIL 300xneg200_sat: got %h expected %h", ra, {1'b0, 20'hF15A0}); end
        n_checks++;
        if (rc !== {1'b0, 20'hFF15A}) begin n_fail++; $display("FAIL 300xneg200_shift: got %h expected %h", rc, {1'b0, 20'hFF15A}); end
    endtask

    task automatic test_saturate();
        int lat; logic [20:0] ra, rb, rc;
        mul_once(20'h7FFFF, 20'd2, lat, ra, rb, rc);
        n_checks++;
        if (ra !== {1'b1, 20'h7FFFF}) begin n_fail++; $display("FAIL max_x2_sat: got %h expected %h", ra, {1'b1, 20'h7FFFF}); end
        n_checks++;
        if (rb !== {1'b1, 20'hFFFFE}) begin n_fail++; $display("FAIL max_x2_wrap: got %h expected %h", rb, {1'b1, 20'hFFFFE}); end
        n_checks++;
        if (rc !== {1'b0, 20'h0FFFF}) begin n_fail++; $display("FAIL max_x2_shift: got %h expected %h", rc, {1'b0, 20'h0FFFF}); end
        mul_once(20'h80000, 20'd2, lat, ra, rb, rc);
        n_checks++;
        if (ra !== {1'b1, 20'h80000}) begin n_fail++; $display("FAIL min_x2_sat: got %h expected %h", ra, {1'b1, 20'h80000}); end
        n_checks++;
        if (rb !== {1'b1, 20'h00000}) begin n_fail++; $display("FAIL min_x2_wrap: got %h expected %h", rb, {1'b1, 20'h00000}); end
        n_checks++;
        if (rc !== {1'b0, 20'hF0000}) begin n_fail++; $display("FAIL min_x2_shift: got %h expected %h", rc, {1'b0, 20'hF0000}); end
        mul_once(20'h80000, 20'h80000, lat, ra, rb, rc); // min * min = +2^38
        n_checks++;
        if (ra !== {1'b1, 20'h7FFFF}) begin n_fail++; $display("FAIL min_x_min_sat: got %h expected %h", ra, {1'b1, 20'h7FFFF}); end
        n_checks++;
        if (rb !== {1'b1, 20'h00000}) begin n_fail++; $display("FAIL min_x_min_wrap: got %h expected %h", rb, {1'b1, 20'h00000}); end
        n_checks++;
        if (rc !== {1'b1, 20'h7FFFF}) begin n_fail++; $display("FAIL min_x_min_shift: got %h expected %h", rc, {1'b1, 20'h7FFFF}); end
        mul_once(20'h7FFFF, 20'd1, lat, ra, rb, rc);     // exactly at the positive limit
        n_checks++;
        if (ra !== {1'b0, 20'h7FFFF}) begin n_fail++; $display("FAIL max_x1_sat: got %h expected %h", ra, {1'b0, 20'h7FFFF}); end
        n_checks++;
        if (rc !== {1'b0, 20'h07FFF}) begin n_fail++; $display("FAIL max_x1_shift: got %h expected %h", rc, {1'b0, 20'h07FFF}); end
    endtask

    task automatic test_shift();
        int lat; logic [20:0] ra, rb, rc;
        mul_once(20'd100, 20'd3, lat, ra, rb, rc);
        n_checks++;
        if (ra !== {1'b0, 20'h0012C}) begin n_fail++; $display("FAIL 100x3_noshift: got %h expected %h", ra, {1'b0, 20'h0012C}); end
        n_checks++;
        if (rc !== {1'b0, 20'h00012}) begin n_fail++; $display("FAIL 100x3_shift: got %h expected %h", rc, {1'b0, 20'h00012}); end
        mul_once(20'hFFF9C, 20'd3, lat, ra, rb, rc);     // -100 * 3
        n_checks++;
        if (ra !== {1'b0, 20'hFFED4}) begin n_fail++; $display("FAIL neg100x3_noshift: got %h expected %h", ra, {1'b0, 20'hFFED4}); end
        n_checks++;
        if (rc !== {1'b0, 20'hFFFED}) begin n_fail++; $display("FAIL neg100x3_shift: got %h expected %h", rc, {1'b0, 20'hFFFED}); end
    endtask

    // Streams k*1 for k = 1..6 while stalling either out_ready (kind 0) or ce (kind 1).
    task automatic run_stream(input int kind, input int stall_start, input int stall_len);
        int          next;
        int          cyc;
        logic        stall, prev_stall, prev_valid, fire, exp_rdy;
        logic [19:0] prev_dout;
        got_n = 0; next = 1; cyc = 0;
        prev_stall = 1'b0; prev_valid = 1'b0; prev_dout = '0;
        din1 = 20'd1;
        while (got_n < 6 && cyc < 60) begin
            stall     = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            out_ready = !(stall && kind == 0);
            ce        = !(stall && kind == 1);
            in_valid  = (next <= 6);
            din0      = 20'(next);
            #1;
            if (stall && prev_stall && (kind == 1 || prev_valid)) begin
                n_checks++;
                if ({if_a.out_valid, if_a.dout} !== {prev_valid, prev_dout}) begin
                    n_fail++;
                    $display("FAIL freeze_k%0d_c%0d: got %b/%h expected %b/%h", kind, cyc,
                             if_a.out_valid, if_a.dout, prev_valid, prev_dout);
                end
            end
            exp_rdy = ce && (!if_a.out_valid || out_ready);
            n_checks++;
            if (if_a.in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL in_ready_k%0d_c%0d: got %b expected %b", kind, cyc, if_a.in_ready, exp_rdy);
            end
            if (if_a.out_valid === 1'b1 && out_ready && ce && got_n < 8) begin
                got[got_n] = if_a.dout;
                got_n++;
            end
            fire       = in_valid && (if_a.in_ready === 1'b1);
            prev_stall = stall;
            prev_valid = if_a.out_valid;
            prev_dout  = if_a.dout;
            @(posedge ap_clk); #1;
            if (fire) next++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
    endtask

    task automatic test_back_pressure();
        run_stream(0, 0, 5);
        n_checks++;
        if (got_n !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got_n || got[i] !== 20'(i + 1)) begin
                n_fail++;
                $display("FAIL bp_order_%0d: got %h expected %h", i, (i < got_n) ? got[i] : 20'hxxxxx, 20'(i + 1));
            end
        end
    endtask

    task automatic test_ce_stall();
        run_stream(1, 2, 4);
        n_checks++;
        if (got_n !== 6) begin n_fail++; $display("FAIL ce_count: got %0d expected 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got_n || got[i] !== 20'(i + 1)) begin
                n_fail++;
                $display("FAIL ce_order_%0d: got %h expected %h", i, (i < got_n) ? got[i] : 20'hxxxxx, 20'(i + 1));
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat; int stale; logic [20:0] ra, rb, rc;
        out_ready = 1'b1; ce = 1'b1; din1 = 20'd1;
        for (int k = 0; k < 3; k++) begin
            din0 = 20'(7 + k); in_valid = 1'b1;
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (if_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_valid: got %b expected 1", if_a.out_valid); end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_a.out_valid, if_a.ovf, if_a.dout} !== 22'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b/%h expected 0/0/00000", if_a.out_valid, if_a.ovf, if_a.dout);
        end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(posedge ap_clk); #1;
            if (if_a.out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale !== 0) begin n_fail++; $display("FAIL stale_after_reset: got %0d valid cycles expected 0", stale); end
        mul_once(20'd2, 20'd3, lat, ra, rb, rc);
        n_checks++;
        if (ra !== {1'b0, 20'h00006} || lat !== 3) begin
            n_fail++;
            $display("FAIL post_reset_mul: got %h lat %0d expected %h lat 3", ra, lat, {1'b0, 20'h00006});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_signed();
        test_saturate();
        test_shift();
        test_back_pressure();
        test_ce_stall();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
